// File: rtl/hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// hit_judge : GPIO box-code synchroniser/debouncer, hit FSM and scorer.
// Optional HIT_PENALTY_EN: wrong hits decrement the score.      Rev 1.0
// ============================================================================
module hit_judge #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LOCKOUT_CYCLES  = 12500000,
  parameter int SOUND_CYCLES    = 5000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  GPIO_1,
  input  logic [2:0]  mif_control_signal,
  output logic [2:0]  box_address,
  output logic        hit_valid,
  output logic [2:0]  hit_box,
  output logic        hit_correct,
  output logic [10:0] score,
  output logic        play_sound
);

  localparam int c_DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam int c_LK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int c_SND_W = $clog2(SOUND_CYCLES + 1);

  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [c_LK_W-1:0]  c_LK_LAST  = c_LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [c_SND_W-1:0] c_SND_LOAD = c_SND_W'(SOUND_CYCLES);
  localparam logic [10:0]        c_SCORE_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HIT     = 2'd1,
    S_LOCKOUT = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [2:0]         r_meta;
  logic [2:0]         r_sync;
  logic [2:0]         r_sync_d;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic [2:0]         r_box;
  state_t             r_state;
  state_t             w_next;
  logic [c_LK_W-1:0]  r_lk_cnt;
  logic [2:0]         r_hit_box;
  logic [10:0]        r_score;
  logic [c_SND_W-1:0] r_snd_cnt;
  logic               w_hit_valid;
  logic               w_hit_correct;
`ifdef HIT_PENALTY_EN
  logic               w_hit_wrong;
`endif

  // The counter saturates at DEBOUNCE_CYCLES-2 because the first unchanged
  // edge is the one that clears it; the load edge follows D-1 further edges.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_meta   <= 3'd0;
      r_sync   <= 3'd0;
      r_sync_d <= 3'd0;
      r_db_cnt <= '0;
      r_box    <= 3'd0;
    end else begin
      r_meta   <= GPIO_1;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      if (r_sync != r_sync_d) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_box <= r_sync;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Target is taken straight from mif_control_signal during the HIT cycle,
  // so a change landing on that cycle is judged with the new value.
  always_comb begin
    w_next        = r_state;
    w_hit_valid   = 1'b0;
    w_hit_correct = 1'b0;
`ifdef HIT_PENALTY_EN
    w_hit_wrong   = 1'b0;
`endif
    case (r_state)
      S_IDLE:    if (r_box != 3'd0) w_next = S_HIT;
      S_HIT: begin
        w_next        = S_LOCKOUT;
        w_hit_valid   = 1'b1;
        w_hit_correct = (mif_control_signal != 3'd0) && (mif_control_signal == r_hit_box);
`ifdef HIT_PENALTY_EN
        w_hit_wrong   = (mif_control_signal != 3'd0) && (mif_control_signal != r_hit_box);
`endif
      end
      S_LOCKOUT: if (r_lk_cnt == c_LK_LAST) w_next = S_RELEASE;
      S_RELEASE: if (r_box == 3'd0) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || (r_state != S_LOCKOUT)) begin
      r_lk_cnt <= '0;
    end else begin
      r_lk_cnt <= r_lk_cnt + c_LK_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hit_box <= 3'd0;
    end else if ((r_state == S_IDLE) && (r_box != 3'd0)) begin
      r_hit_box <= r_box;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_score   <= 11'd0;
      r_snd_cnt <= '0;
    end else begin
      if (r_snd_cnt != '0) begin
        r_snd_cnt <= r_snd_cnt - c_SND_W'(1);
      end
      if (w_hit_correct) begin
        r_snd_cnt <= c_SND_LOAD;
        if (r_score != c_SCORE_MAX) begin
          r_score <= r_score + 11'd1;
        end
      end
`ifdef HIT_PENALTY_EN
      else if (w_hit_wrong && (r_score != 11'd0)) begin
        r_score <= r_score - 11'd1;
      end
`endif
    end
  end

  assign box_address = r_box;
  assign hit_valid   = w_hit_valid;
  assign hit_box     = r_hit_box;
  assign hit_correct = w_hit_correct;
  assign score       = r_score;
  assign play_sound  = (r_snd_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_hit_judge : directed stimulus, timestamp-based reference model.  Rev 1.0
// ============================================================================
module tb_hit_judge;
  localparam int D = 4;
  localparam int L = 8;
  localparam int S = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  gpio;
  logic [2:0]  mif;
  logic [2:0]  box;
  logic        hv;
  logic [2:0]  hb;
  logic        hc;
  logic [10:0] score;
  logic        snd;

  always #5 clk = ~clk;

  hit_judge #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .SOUND_CYCLES(S)) dut (
    .CLOCK_50(clk), .reset(rst), .GPIO_1(gpio), .mif_control_signal(mif),
    .box_address(box), .hit_valid(hv), .hit_box(hb), .hit_correct(hc),
    .score(score), .play_sound(snd)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_hits = 0;
  int n_snd  = 0;
  int n_corr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a box code is accepted once D consecutive samples agree;
  // a hit fires when a nonzero accepted code meets a released scorer, and the
  // scorer re-arms only after the lockout window and an accepted zero.
  bit          m_on = 1'b0;
  logic [2:0]  m_q[$];
  logic [2:0]  m_box;
  logic [2:0]  m_hit_box;
  bit          m_hit;
  bit          m_released;
  int          m_last_hit;
  int          m_score;
  int          m_snd_last;

  always @(posedge clk) begin : model
    bit judge;
    bit eq;
    cyc++;
    if (rst) begin
      m_on = 1'b1;
      m_q.delete();
      for (int i = 0; i <= D; i++) m_q.push_back(3'd0);
      m_box = 3'd0; m_hit_box = 3'd0; m_hit = 1'b0; m_released = 1'b1;
      m_last_hit = 0; m_score = 0; m_snd_last = -1;
    end else if (m_on) begin
      judge = m_hit;
      m_hit = (m_box != 3'd0) && m_released;
      if (m_hit) begin
        m_released = 1'b0;
        m_last_hit = cyc;
        m_hit_box  = m_box;
      end else if (!m_released && (cyc >= m_last_hit + 2 + L) && (m_box == 3'd0)) begin
        m_released = 1'b1;
      end
      if (judge && (mif != 3'd0)) begin
        if (mif == m_hit_box) begin
          if (m_score < 2047) m_score++;
          m_snd_last = cyc + S - 1;
        end else begin
`ifdef HIT_PENALTY_EN
          if (m_score > 0) m_score--;
`endif
        end
      end
      eq = 1'b1;
      for (int i = 1; i < D; i++) if (m_q[i] !== m_q[0]) eq = 1'b0;
      if (eq) m_box = m_q[D-1];
      m_q.push_back(gpio);
      void'(m_q.pop_front());
    end
    #1;
    if (m_on) begin
      check("box_address", box, m_box);
      check("hit_valid", hv, m_hit);
      check("hit_box", hb, m_hit_box);
      check("score", score, m_score);
      check("play_sound", snd, (cyc <= m_snd_last) ? 1 : 0);
      if (m_hit) check("hit_correct", hc, ((mif != 3'd0) && (mif == m_hit_box)) ? 1 : 0);
      if (hv === 1'b1) n_hits++;
      if (snd === 1'b1) n_snd++;
      if ((hv === 1'b1) && (hc === 1'b1)) n_corr++;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    gpio = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strike(input logic [2:0] code, input int hold, input int gap);
    gpio = code;
    repeat (hold) @(negedge clk);
    gpio = 3'd0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_hit(input string name, input int budget);
    int n = 0;
    while ((hv !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(name, hv, 1);
  endtask

  int k, r, s0, h0, c0;
  int wrong_exp;

  initial begin
`ifdef HIT_PENALTY_EN
    wrong_exp = 0;
`else
    wrong_exp = 1;
`endif
    rst = 1'b1; gpio = 3'd0; mif = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_score", score, 0);
    check("rst_valid", hv, 0);
    check("rst_sound", snd, 0);
    check("rst_box", box, 0);
    rst = 1'b0;

    // 1: correct hit, exact latency and sound length
    mif = 3'd3;
    k = cyc + 1;
    gpio = 3'd3;
    while (cyc < k + 5) @(negedge clk);
    check("t1_no_early_hit", hv, 0);
    check("t1_box_ready", box, 3);
    @(negedge clk);
    check("t1_valid", hv, 1);
    check("t1_hit_box", hb, 3);
    check("t1_correct", hc, 1);
    check("t1_score_before", score, 0);
    s0 = n_snd;
    repeat (13) @(negedge clk);
    check("t1_score_after", score, 1);
    check("t1_sound_len", n_snd - s0, 5);
    gpio = 3'd0;
    repeat (10) @(negedge clk);

    // 2: bounce shorter than the debounce window
    reset_dut();
    mif = 3'd5;
    h0 = n_hits;
    for (int i = 0; i < 10; i++) begin
      gpio = 3'd5; repeat (2) @(negedge clk);
      check("t2_box_stable", box, 0);
      gpio = 3'd0; repeat (2) @(negedge clk);
      check("t2_box_stable", box, 0);
    end
    repeat (10) @(negedge clk);
    check("t2_no_hit", n_hits - h0, 0);
    check("t2_score", score, 0);

    // 3: hold, release, re-strike
    reset_dut();
    mif = 3'd2;
    h0 = n_hits;
    gpio = 3'd2;
    repeat (100) @(negedge clk);
    check("t3_single_hit", n_hits - h0, 1);
    gpio = 3'd0;
    repeat (10) @(negedge clk);
    gpio = 3'd2;
    repeat (30) @(negedge clk);
    check("t3_second_hit", n_hits - h0, 2);
    check("t3_score", score, 2);
    gpio = 3'd0;
    repeat (10) @(negedge clk);

    // 4: wrong hits after one correct hit
    reset_dut();
    mif = 3'd1;
    strike(3'd1, 18, 8);
    check("t4_preload", score, 1);
    s0 = n_snd;
    strike(3'd4, 18, 8);
    check("t4_wrong1", score, wrong_exp);
    strike(3'd4, 18, 8);
    check("t4_wrong2", score, wrong_exp);
    check("t4_no_sound", n_snd - s0, 0);

    // 5: lobby, then saturation
    reset_dut();
    mif = 3'd0;
    h0 = n_hits; c0 = n_corr;
    strike(3'd6, 18, 8);
    check("t5_lobby_hit", n_hits - h0, 1);
    check("t5_lobby_incorrect", n_corr - c0, 0);
    check("t5_lobby_score", score, 0);
    mif = 3'd3;
    for (int i = 0; i < 2047; i++) strike(3'd3, 18, 8);
    check("t5_sat_reach", score, 2047);
    strike(3'd3, 18, 8);
    check("t5_sat_hold", score, 2047);

    // 6: reset during lockout with the code still held
    reset_dut();
    mif = 3'd3;
    gpio = 3'd3;
    wait_hit("t6_first_hit", 40);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_box", box, 0);
    check("t6_rst_valid", hv, 0);
    check("t6_rst_hit_box", hb, 0);
    check("t6_rst_correct", hc, 0);
    check("t6_rst_score", score, 0);
    check("t6_rst_sound", snd, 0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("t6_quiet", hv, 0);
    end
    @(negedge clk);
    check("t6_rehit_at_7", hv, 1);
    gpio = 3'd0;
    repeat (20) @(negedge clk);

    // 7: target changes on the HIT cycle itself
    reset_dut();
    mif = 3'd0;
    gpio = 3'd5;
    wait_hit("t7_hit", 40);
    mif = 3'd5;
    @(negedge clk);
    check("t7_new_target_score", score, 1);
    check("t7_new_target_sound", snd, 1);
    gpio = 3'd0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
